mul_unit: RTL and testbench
===========================

# mul_unit

Iterative 32-bit multiply unit for KGP-RISC, sitting directly downstream of the register file. It takes the two register read operands, computes a 64-bit product over several cycles, and drives the register-file write port with the low word. The high word is kept in an internal HI register, which a single-cycle MFHI operation returns. A start/busy/done handshake lets the control unit stall issue while a multiply is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width
- ADDR_WIDTH, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only when busy=0
- op  in  2  operation: 00 MULU, 01 MUL (signed), 10 MFHI, 11 NOP
- srcA  in  WIDTH  operand A, from reg1Out
- srcB  in  WIDTH  operand B, from reg2Out
- destAddr  in  ADDR_WIDTH  destination register
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle completion pulse
- writeEnable  out  1  register-file write strobe
- writeAddr  out  ADDR_WIDTH  register-file write address
- writeData  out  WIDTH  register-file write data
- hi  out  WIDTH  current HI register (debug/observability)

## Operation
States and transitions:
- IDLE
  - start=1 with op MULU/MUL: capture operands, op and destAddr; go to CALC.
  - start=1 with op MFHI/NOP: go to DONE.
  - Otherwise: stay in IDLE.
- CALC: 32 shift-add iterations, one per cycle, on the unsigned magnitudes; iteration counter 0..31; go to FIX after iteration 31.
- FIX
  - MUL: negate the 64-bit product if sign(A) XOR sign(B).
  - MULU: pass the product through unchanged.
  - Register the result into lo/HI; go to DONE.
- DONE: done=1 and writeEnable=1 for this single cycle. Behaves like IDLE for start, so back-to-back issue is accepted.

Datapath rules:
- Signed magnitudes: |x| is computed in 32-bit unsigned, so INT_MIN maps to 0x8000_0000 with no overflow.
- Product: 64 bits. writeData = product[31:0]; HI = product[63:32].
- MFHI: writeData = HI; HI unchanged.
- NOP: writeData = 0, writeEnable = 0, done = 1.
- HI is updated only at FIX.
- writeAddr is the captured destAddr. The unit does not special-case register 0.

Handshake and boundaries:
- busy=1 in CALC and FIX only.
- start while busy=1 is ignored; no queuing.
- op, srcA, srcB and destAddr may change freely after the capture edge.
- Reset mid-operation: the next edge returns the unit to IDLE, discards the product and produces no write or done pulse.

## Timing
- Reset values (while rst=0 at an edge): state IDLE, busy 0, done 0, writeEnable 0, writeAddr 0, writeData 0, hi 0, counter 0.
- Multiply latency: the capture edge is E0. busy is high from after E0 through E0+33. done/writeEnable/writeData are valid in the cycle after edge E0+33, i.e. a 34-cycle latency.
- MFHI/NOP latency: done is valid in the cycle after the capture edge (1 cycle).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back: start high during the DONE cycle is captured at that cycle's closing edge.

## Structure
- Shared package kgp_mul_pkg holds:
  - op encodings (OP_MULU, OP_MUL, OP_MFHI, OP_NOP)
  - the state enum (IDLE, CALC, FIX, DONE)
  - WIDTH and ITER=32 constants
- One sub-module, seq_mul_core:
  - unsigned shift-add engine: 33-bit accumulator plus 32-bit multiplier shift register, and the 5-bit counter
  - load/step controls, done-iterating flag
- The parent block holds the FSM, sign handling, HI and the output registers.

## Test plan
- Reset: hold rst=0 for 3 cycles mid-idle → all outputs 0; hi=0.
- MULU: srcA=0xFFFF_FFFF, srcB=0x0000_0002, destAddr=5 → after 34 cycles writeData=0xFFFF_FFFE, writeAddr=5, hi=0x0000_0001, one-cycle writeEnable.
- MUL with negative operand: srcA=0xFFFF_FFFD (-3), srcB=7 → writeData=0xFFFF_FFEB, hi=0xFFFF_FFFF.
- MUL edge case: srcA=0x8000_0000, srcB=0xFFFF_FFFF → writeData=0x8000_0000, hi=0x0000_0000.
- Handshake, MFHI and back-to-back:
  - start MULU 6×7 to r3.
  - Pulse start with op=MUL at cycle 10 → ignored; the result is 42 to r3 at cycle 34.
  - Then MFHI to r4 issued in the DONE cycle → writeData=0, writeAddr=4 one cycle later.
- Reset mid-operation: start MULU, drive rst=0 at cycle 10 for one edge → busy=0 next cycle, no done/writeEnable pulse for 40 cycles, hi=0.

Source files
------------

// File: rtl/kgp_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_mul_pkg
// Description : Shared op encodings, FSM state codes and sizing constants
// Revision    : 1.0
// ============================================================================
package kgp_mul_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_MFHI = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mul_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_if
// Description : Issue and register-file write bundle of the multiply unit
// Revision    : 1.0
// ============================================================================
interface mul_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic [1:0]            op;
    logic [WIDTH-1:0]      srcA;
    logic [WIDTH-1:0]      srcB;
    logic [ADDR_WIDTH-1:0] destAddr;
    logic                  busy;
    logic                  done;
    logic                  writeEnable;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [WIDTH-1:0]      writeData;
    logic [WIDTH-1:0]      hi;

    modport master (
        output start, op, srcA, srcB, destAddr,
        input  busy, done, writeEnable, writeAddr, writeData, hi
    );

    modport slave (
        input  start, op, srcA, srcB, destAddr,
        output busy, done, writeEnable, writeAddr, writeData, hi
    );
endinterface
`default_nettype wire

// File: rtl/seq_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_core
// Description : Unsigned radix-2 shift-add multiply engine, one bit per step
// Revision    : 1.0
// ============================================================================
module seq_mul_core #(
    parameter int WIDTH  = 32,
    parameter int N_ITER = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               load,
    input  wire logic               step,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    output logic      [2*WIDTH-1:0] product,
    output logic                    last
);
    localparam int             CW     = $clog2(N_ITER);
    localparam logic [CW-1:0]  c_last = CW'(N_ITER - 1);

    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_mcand;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   w_sum;

    assign w_sum = r_acc + {1'b0, (r_mplr[0] ? r_mcand : '0)};

    // {acc, mplr} shifts right as one register; the low product bits fill mplr
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_mplr  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_acc   <= '0;
            r_mplr  <= b;
            r_mcand <= a;
            r_cnt   <= '0;
        end else if (step) begin
            r_acc   <= {1'b0, w_sum[WIDTH:1]};
            r_mplr  <= {w_sum[0], r_mplr[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign product = {r_acc[WIDTH-1:0], r_mplr};
    assign last    = (r_cnt == c_last);
endmodule
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit
// Description : Iterative signed/unsigned multiply with HI register and MFHI
// Revision    : 1.0
// ============================================================================
module mul_unit
    import kgp_mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mul_unit_if.slave   bus
);
    logic [1:0]            r_state;
    logic                  r_neg;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [WIDTH-1:0]      r_wdata;
    logic [WIDTH-1:0]      r_hi;

    logic                  w_is_mul;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic [WIDTH-1:0]      w_mag_a;
    logic [WIDTH-1:0]      w_mag_b;
    logic [2*WIDTH-1:0]    w_prod;
    logic [2*WIDTH-1:0]    w_fixed;

    assign w_is_mul = (bus.op == OP_MUL);
    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_load   = w_accept && !bus.op[1];
    assign w_step   = (r_state == ST_CALC);

    // Magnitudes stay unsigned, so the most negative operand maps cleanly
    assign w_mag_a = (w_is_mul && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
    assign w_mag_b = (w_is_mul && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;

    seq_mul_core #(
        .WIDTH  (WIDTH),
        .N_ITER (ITER)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .step    (w_step),
        .a       (w_mag_a),
        .b       (w_mag_b),
        .product (w_prod),
        .last    (w_last)
    );

    assign w_fixed = r_neg ? -w_prod : w_prod;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_hi    <= '0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_waddr <= bus.destAddr;
                        case (bus.op)
                            OP_MULU, OP_MUL: begin
                                r_neg   <= w_is_mul && (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
                                r_busy  <= 1'b1;
                                r_state <= ST_CALC;
                            end
                            OP_MFHI: begin
                                r_wdata <= r_hi;
                                r_done  <= 1'b1;
                                r_we    <= 1'b1;
                                r_state <= ST_DONE;
                            end
                            default: begin
                                r_wdata <= '0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_wdata <= w_fixed[WIDTH-1:0];
                    r_hi    <= w_fixed[2*WIDTH-1:WIDTH];
                    r_done  <= 1'b1;
                    r_we    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.writeEnable = r_we;
    assign bus.writeAddr   = r_waddr;
    assign bus.writeData   = r_wdata;
    assign bus.hi          = r_hi;
endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_unit
// Description : Directed-vector scoreboard bench for mul_unit
// Revision    : 1.0
// ============================================================================
module tb_mul_unit;
    import kgp_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_unit_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

    mul_unit #(.WIDTH(32), .ADDR_WIDTH(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] wd;
        logic [31:0] hi;
        logic        we;
        logic [4:0]  wa;
        int          cyc;
    } exp_t;

    exp_t q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("writeData",   bus.writeData,   e.wd);
                chk("hi",          bus.hi,          e.hi);
                chk("writeEnable", bus.writeEnable, e.we);
                if (e.we) chk("writeAddr", bus.writeAddr, e.wa);
                chk("done_cycle",  cyc,             e.cyc);
            end
        end
    end

    // Called at a negedge; leaves start low one negedge later
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic push,
                         input logic [31:0] ewd, input logic [31:0] ehi, input logic ewe);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.srcA     = a;
        bus.srcB     = b;
        bus.destAddr = d;
        if (push) q.push_back('{ewd, ehi, ewe, d, cyc + (op[1] ? 1 : 34)});
        @(negedge clk);
        bus.start    = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.srcA     = $urandom;
        bus.srcB     = $urandom;
        bus.destAddr = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done (cycle %0d)", cyc);
        end
    endtask

    task automatic finish_pulse();
        wait_done();
        @(negedge clk);
        chk("done_width", bus.done, 1'b0);
        chk("we_width",   bus.writeEnable, 1'b0);
        chk("busy_idle",  bus.busy, 1'b0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op       = OP_NOP;
        bus.srcA     = '0;
        bus.srcB     = '0;
        bus.destAddr = '0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  bus.busy,        1'b0);
        chk("rst_done",  bus.done,        1'b0);
        chk("rst_we",    bus.writeEnable, 1'b0);
        chk("rst_waddr", bus.writeAddr,   5'd0);
        chk("rst_wdata", bus.writeData,   32'd0);
        chk("rst_hi",    bus.hi,          32'd0);
        rst = 1'b1;
        @(negedge clk);

        // MULU 0xFFFFFFFF * 2
        issue(OP_MULU, 32'hFFFF_FFFF, 32'h2, 5'd5, 1'b1, 32'hFFFF_FFFE, 32'h1, 1'b1);
        chk("busy_after_capture", bus.busy, 1'b1);
        finish_pulse();

        // MUL -3 * 7, then MFHI and NOP against the resulting HI
        issue(OP_MUL, 32'hFFFF_FFFD, 32'h7, 5'd6, 1'b1, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b1);
        finish_pulse();
        issue(OP_MFHI, 32'h1234_5678, 32'h9, 5'd8, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_pulse();
        issue(OP_NOP, 32'h5, 32'h5, 5'd9, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0);
        finish_pulse();

        // Reset in the middle of a multiply: no write, HI cleared
        issue(OP_MULU, 32'h5, 32'h5, 5'd2, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_hi",   bus.hi,   32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("midrst_no_done", bus.done,        1'b0);
            chk("midrst_no_we",   bus.writeEnable, 1'b0);
        end

        // MUL INT_MIN * -1
        issue(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'h8000_0000, 32'h0, 1'b1);
        finish_pulse();

        // MULU 6*7, ignored start while busy, MFHI issued in the DONE cycle
        issue(OP_MULU, 32'd6, 32'd7, 5'd3, 1'b1, 32'd42, 32'h0, 1'b1);
        repeat (8) @(negedge clk);
        issue(OP_MUL, 32'd100, 32'd100, 5'd9, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("busy_ignores_start", bus.busy, 1'b1);
        wait_done();
        issue(OP_MFHI, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 1'b1);
        chk("b2b_mfhi_done", bus.done, 1'b1);
        finish_pulse();

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
